// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared types and helpers for the multi-channel LED PWM dimmer.
//   mode_t      : mode encoding (MANUAL=0, BREATHE=1, OFF=2, 3 is illegal)
//   clog2_min1  : bit width needed for a counter/index, never less than 1
package led_pwm_pkg;

   typedef enum logic [1:0] {
      MODE_MANUAL  = 2'd0,
      MODE_BREATHE = 2'd1,
      MODE_OFF     = 2'd2,
      MODE_BAD     = 2'd3
   } mode_t;

   function automatic int clog2_min1(input int v);
      return ($clog2(v) < 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/led_pwm_multi_btn_edge.sv
// btn_edge: two-flop synchroniser for a raw push-button followed by a
// registered rising-edge detector.
//   clk   : system clock
//   rst   : synchronous active-low reset
//   btn   : raw asynchronous button level
//   pulse : one-clk pulse, registered, two clks after the synchronised rise
// A button held through reset produces one pulse once it is seen high after
// reset, because prev comes out of reset as 0.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   logic s1, s2, prev;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         s1    <= btn;
         s2    <= s1;
         prev  <= s2;
         pulse <= s2 & ~prev;
      end
   end

endmodule

// File: rtl/led_pwm_multi.sv
// led_pwm_multi: CH_N-channel LED PWM dimmer driven by up/down/mode buttons.
//   clk, rst  : system clock, synchronous active-low reset
//   btn_up/dn : raw buttons, step the duty of channel ch_sel (MANUAL only)
//   btn_mode  : raw button, cycles MANUAL -> BREATHE -> OFF -> MANUAL
//   ch_sel    : channel addressed by up/down
//   led       : registered PWM outputs
//   mode      : current mode
//   duty_o    : manual duty of ch_sel (0 when ch_sel is out of range)
// Each channel's compare value is a shadow copy taken at the PWM period
// boundary, so a duty change never distorts the period in progress.
module led_pwm_multi import led_pwm_pkg::*; #(
   parameter  int CH_N        = 8,
   parameter  int LEVELS      = 10,
   parameter  int PRESCALE    = 1,
   parameter  int BREATHE_DIV = 1000,
   localparam int CSW         = clog2_min1(CH_N),
   localparam int LW          = $clog2(LEVELS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            btn_up,
   input  logic            btn_dn,
   input  logic            btn_mode,
   input  logic [CSW-1:0]  ch_sel,
   output logic [CH_N-1:0] led,
   output logic [1:0]      mode,
   output logic [LW-1:0]   duty_o
);

   localparam int PSW = clog2_min1(PRESCALE);
   localparam int DVW = clog2_min1(BREATHE_DIV);
   localparam logic [LW-1:0]  LV_MAX  = LW'(LEVELS);
   localparam logic [LW-1:0]  PH_LAST = LW'(LEVELS - 1);
   localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
   localparam logic [DVW-1:0] DV_LAST = DVW'(BREATHE_DIV - 1);

   logic pu, pd, pm;

   btn_edge u_up   (.clk(clk), .rst(rst), .btn(btn_up),   .pulse(pu));
   btn_edge u_dn   (.clk(clk), .rst(rst), .btn(btn_dn),   .pulse(pd));
   btn_edge u_mode (.clk(clk), .rst(rst), .btn(btn_mode), .pulse(pm));

   // ---------------- mode FSM ----------------
   mode_t mode_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode_q <= MODE_MANUAL;
      end else begin
         case (mode_q)
            MODE_MANUAL:  if (pm) mode_q <= MODE_BREATHE;
            MODE_BREATHE: if (pm) mode_q <= MODE_OFF;
            MODE_OFF:     if (pm) mode_q <= MODE_MANUAL;
            default:      mode_q <= MODE_MANUAL;
         endcase
      end
   end

   assign mode = mode_q;

   // ---------------- timebase ----------------
   logic [PSW-1:0] presc;
   logic [LW-1:0]  phase;
   logic           tick, bnd;

   assign tick = (presc == PS_LAST);
   assign bnd  = tick && (phase == PH_LAST);

   always_ff @(posedge clk) begin
      if (!rst) begin
         presc <= '0;
         phase <= '0;
      end else if (tick) begin
         presc <= '0;
         phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   // ---------------- breathe ramp ----------------
   // Level moves one step every BREATHE_DIV periods. The direction flips on
   // the step that lands on an end value, so 0 and LEVELS are each shown for
   // exactly one step interval, like every other level.
   logic [LW-1:0]  level;
   logic           dir_dn;
   logic [DVW-1:0] div;
   logic           enter_br;

   assign enter_br = pm && (mode_q == MODE_MANUAL);

   always_ff @(posedge clk) begin
      if (!rst || enter_br) begin
         level  <= '0;
         dir_dn <= 1'b0;
         div    <= '0;
      end else if (mode_q == MODE_BREATHE && bnd) begin
         if (div == DV_LAST) begin
            div <= '0;
            if (!dir_dn) begin
               level <= level + 1'b1;
               if (level == PH_LAST) dir_dn <= 1'b1;
            end else begin
               level <= level - 1'b1;
               if (level == LW'(1)) dir_dn <= 1'b0;
            end
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   // ---------------- per-channel duty, shadow, output ----------------
   logic [CH_N-1:0][LW-1:0] duty;
   logic [CH_N-1:0][LW-1:0] active;
   logic                    man_step;

   // Simultaneous up and down cancel out.
   assign man_step = (mode_q == MODE_MANUAL) && (pu ^ pd);

   always_ff @(posedge clk) begin
      if (!rst) begin
         duty   <= '0;
         active <= '0;
         led    <= '0;
      end else begin
         for (int i = 0; i < CH_N; i++) begin
            if (man_step && ch_sel == CSW'(i)) begin
               if (pu && duty[i] != LV_MAX)  duty[i] <= duty[i] + 1'b1;
               else if (pd && duty[i] != '0) duty[i] <= duty[i] - 1'b1;
            end
            if (bnd)
               active[i] <= (mode_q == MODE_BREATHE) ? level : duty[i];
            led[i] <= (mode_q != MODE_OFF) && (phase < active[i]);
         end
      end
   end

   always_comb begin
      duty_o = '0;
      for (int i = 0; i < CH_N; i++)
         if (ch_sel == CSW'(i)) duty_o = duty[i];
   end

endmodule

// File: tb/tb_led_pwm_multi.sv
module tb_led_pwm_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_up = 1'b0, btn_dn = 1'b0, btn_mode = 1'b0;
   logic [2:0] ch_sel = 3'd0;
   logic [7:0] led_a;
   logic [5:0] led_b;
   logic [1:0] mode_a, mode_b;
   logic [3:0] duty_a;
   logic [2:0] duty_b;

   always #5 clk = ~clk;

   // A: 8 channels, 10 levels, no prescale, fast breathe.
   led_pwm_multi #(.CH_N(8), .LEVELS(10), .PRESCALE(1), .BREATHE_DIV(2)) dut_a (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_mode(btn_mode),
      .ch_sel(ch_sel), .led(led_a), .mode(mode_a), .duty_o(duty_a));

   // B: 6 channels (out-of-range ch_sel), 7 levels, prescale 3.
   led_pwm_multi #(.CH_N(6), .LEVELS(7), .PRESCALE(3), .BREATHE_DIV(1)) dut_b (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_mode(btn_mode),
      .ch_sel(ch_sel), .led(led_b), .mode(mode_b), .duty_o(duty_b));

   localparam int NCH [2] = '{8, 6};
   localparam int LV  [2] = '{10, 7};
   localparam int PS  [2] = '{1, 3};
   localparam int BD  [2] = '{2, 1};

   int total = 0, bad = 0;
   int e = 0;
   int due_up = -1, due_dn = -1, due_md = -1;

   // Reference model: time-based phase, triangle level from boundary count.
   int m_n [2];
   int m_mode [2];
   int m_b [2];
   int m_duty [2][16];
   int m_act [2][16];
   bit m_led [2][16];

   function automatic int tri_lvl(input int s, input int l);
      int r;
      r = s % (2 * l);
      return (r <= l) ? r : 2 * l - r;
   endfunction

   function automatic logic [31:0] exp_led(input int k);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < NCH[k]; i++) v[i] = m_led[k][i];
      return v;
   endfunction

   function automatic logic [31:0] exp_duty(input int k);
      return (int'(ch_sel) < NCH[k]) ? m_duty[k][int'(ch_sel)] : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d (edge %0d)", tag, obs, exp, e);
      end
   endtask

   task automatic model_edge();
      bit up, dn, md;
      int ph;
      bit bnd;
      up = (due_up == e);
      dn = (due_dn == e);
      md = (due_md == e);
      for (int k = 0; k < 2; k++) begin
         if (!rst) begin
            m_n[k] = 0; m_mode[k] = 0; m_b[k] = 0;
            for (int i = 0; i < 16; i++) begin
               m_duty[k][i] = 0; m_act[k][i] = 0; m_led[k][i] = 0;
            end
         end else begin
            ph  = (m_n[k] / PS[k]) % LV[k];
            bnd = (m_n[k] % PS[k] == PS[k] - 1) && (ph == LV[k] - 1);
            for (int i = 0; i < NCH[k]; i++)
               m_led[k][i] = (m_mode[k] != 2) && (ph < m_act[k][i]);
            if (bnd) begin
               for (int i = 0; i < NCH[k]; i++)
                  m_act[k][i] = (m_mode[k] == 1) ? tri_lvl(m_b[k] / BD[k], LV[k]) : m_duty[k][i];
               if (m_mode[k] == 1) m_b[k]++;
            end
            if (m_mode[k] == 0 && (up != dn) && int'(ch_sel) < NCH[k]) begin
               if (up && m_duty[k][int'(ch_sel)] < LV[k]) m_duty[k][int'(ch_sel)]++;
               if (dn && m_duty[k][int'(ch_sel)] > 0)     m_duty[k][int'(ch_sel)]--;
            end
            if (md) begin
               m_mode[k] = (m_mode[k] + 1) % 3;
               if (m_mode[k] == 1) m_b[k] = 0;
            end
            m_n[k]++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      e++;
      model_edge();
      #1;
      chk("led_a",  32'(led_a),  exp_led(0));
      chk("led_b",  32'(led_b),  exp_led(1));
      chk("mode_a", 32'(mode_a), 32'(m_mode[0]));
      chk("mode_b", 32'(mode_b), 32'(m_mode[1]));
      chk("duty_a", 32'(duty_a), exp_duty(0));
      chk("duty_b", 32'(duty_b), exp_duty(1));
   endtask

   // Raw rise before edge e+1 takes effect on edge e+4.
   task automatic press(input bit u, input bit d, input bit m);
      if (u) due_up = e + 4;
      if (d) due_dn = e + 4;
      if (m) due_md = e + 4;
      btn_up = u; btn_dn = d; btn_mode = m;
      repeat (3) step();
      btn_up = 1'b0; btn_dn = 1'b0; btn_mode = 1'b0;
      repeat (3) step();
   endtask

   task automatic count_hi(input int bit_idx, output int cnt);
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         step();
         cnt += int'(led_a[bit_idx]);
      end
   endtask

   initial begin
      int cnt;
      int r;

      // reset and idle
      repeat (3) step();
      chk("rst_led",  32'(led_a),  0);
      chk("rst_mode", 32'(mode_a), 0);
      chk("rst_duty", 32'(duty_a), 0);
      rst = 1'b1;
      repeat (50) step();
      chk("idle_led", 32'(led_a), 0);

      // three up presses on channel 2
      ch_sel = 3'd2;
      repeat (3) press(1, 0, 0);
      chk("duty3", 32'(duty_a), 3);
      repeat (20) step();
      count_hi(2, cnt);
      chk("hi_cnt3", 32'(cnt), 3);

      // saturation high and low
      repeat (12) press(1, 0, 0);
      chk("duty_sat_hi", 32'(duty_a), 10);
      repeat (20) step();
      count_hi(2, cnt);
      chk("hi_cnt10", 32'(cnt), 10);
      repeat (11) press(0, 1, 0);
      chk("duty_sat_lo", 32'(duty_a), 0);
      repeat (20) step();
      count_hi(2, cnt);
      chk("hi_cnt0", 32'(cnt), 0);

      // simultaneous up+dn
      repeat (5) press(1, 0, 0);
      press(1, 1, 0);
      chk("up_dn_same", 32'(duty_a), 5);

      // out-of-range channel on the 6-channel instance
      ch_sel = 3'd7;
      press(1, 0, 0);
      chk("oob_duty_b", 32'(duty_b), 0);
      chk("ch7_duty_a", 32'(duty_a), 1);
      ch_sel = 3'd5;
      press(1, 0, 0);
      chk("ch5_duty_b", 32'(duty_b), 1);

      // breathe, all-off, back to manual
      ch_sel = 3'd2;
      press(0, 0, 1);
      chk("mode_br", 32'(mode_a), 1);
      repeat (450) step();
      press(0, 0, 1);
      chk("mode_off", 32'(mode_a), 2);
      chk("off_led", 32'(led_a), 0);
      repeat (25) step();
      press(0, 0, 1);
      chk("mode_man", 32'(mode_a), 0);
      chk("duty_restored", 32'(duty_a), 5);
      repeat (30) step();

      // randomized presses at random phases
      for (int it = 0; it < 150; it++) begin
         r = int'($urandom_range(0, 19));
         ch_sel = 3'($urandom_range(0, 7));
         if (r == 0)      press(0, 0, 1);
         else if (r < 9)  press(1, 0, 0);
         else if (r < 17) press(0, 1, 0);
         else if (r < 18) press(1, 1, 0);
         else repeat ($urandom_range(1, 12)) step();
         repeat ($urandom_range(0, 7)) step();
      end

      // reset mid-operation
      rst = 1'b0;
      step();
      chk("rst2_led",  32'(led_a),  0);
      chk("rst2_mode", 32'(mode_a), 0);
      chk("rst2_duty", 32'(duty_a), 0);
      rst = 1'b1;
      repeat (20) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_pwm_multi.md
Name: led_pwm_multi

Overview:
Multi-channel LED PWM dimmer, the parametrised successor of the single-channel switch-stepped dimmer. It drives CH_N LED outputs, each with its own duty level, from debounced-edge up/down/mode buttons. A mode FSM selects per-channel manual dimming, a shared triangular "breathe" ramp, or all-off. Sits between board push-buttons and the LED bank in the lab top level.

Parameters:
CH_N, 8, number of LED channels (1..16)
LEVELS, 10, PWM period in phase ticks; duty range 0..LEVELS inclusive
PRESCALE, 1, clk cycles per phase tick (>=1)
BREATHE_DIV, 1000, PWM periods per breathe-level step (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
btn_up  in  1  raw asynchronous button, increments selected channel
btn_dn  in  1  raw asynchronous button, decrements selected channel
btn_mode  in  1  raw asynchronous button, advances mode
ch_sel  in  CSW=max(1,$clog2(CH_N))  channel addressed by btn_up/btn_dn
led  out  CH_N  registered PWM outputs
mode  out  2  current mode: 0 MANUAL, 1 BREATHE, 2 ALL_OFF
duty_o  out  LW=$clog2(LEVELS+1)  manual duty of ch_sel; 0 if ch_sel>=CH_N

Behaviour:
- Reset (rst==0 at posedge): all duty regs, shadow duties, phase, prescale, breathe level/divider, sync/edge flops = 0; breathe dir = up; mode = MANUAL; led = 0.
- Buttons: 2-flop synchroniser plus a previous-value flop; pulse = sync & ~prev, exactly one clk per rising edge. Raw rise before edge k gives pulse in cycle k+2; state update on edge k+3.
- Mode FSM on btn_mode pulse: MANUAL->BREATHE->ALL_OFF->MANUAL. Encoding 3 is illegal and returns to MANUAL on the next clk.
- MANUAL: up pulse -> duty[ch_sel]+1, saturating at LEVELS; dn pulse -> -1, saturating at 0. up and dn in the same cycle -> no change. ch_sel>=CH_N -> ignored. In other modes up/dn are ignored and duty regs are retained.
- Timebase: prescale counts 0..PRESCALE-1; tick at wrap. Phase advances on tick and wraps LEVELS-1->0. Period boundary = tick with phase==LEVELS-1.
- Shadow: per-channel active duty is loaded from the source (manual duty[i], or breathe level in BREATHE) only at the period boundary. Mid-period duty changes never alter the current period.
- BREATHE: entering the mode sets level=0, dir=up, divider=0. The divider counts period boundaries; every BREATHE_DIV boundaries, level steps ±1. At LEVELS dir flips to down; at 0 dir flips to up, so the peak and floor each hold for one step interval. All channels use level.
- led[i] <= (mode!=ALL_OFF) && (phase < active[i]); one-cycle registered latency. Duty 0 gives constant low. Duty LEVELS gives constant high.
- ALL_OFF: led=0 from the clk after the mode change. Timebase keeps running.
- Reset mid-operation: everything returns to reset values on that edge. No pulse is generated for a button held through reset until it is released and pressed again, or until it is seen high after release (prev=0, so one pulse).

Decomposition:
- Package led_pwm_pkg: mode typedef/localparams MODE_MANUAL=2'd0, MODE_BREATHE=2'd1, MODE_OFF=2'd2; width helper function (max(1,clog2)).
- Sub-module btn_edge (synchroniser + rising-edge pulse, synchronous active-low rst), instantiated three times.

Test Plan:
1. rst=0 for 3 clk with buttons low -> led=0, mode=0, duty_o=0. Release, idle 50 clk -> outputs unchanged.
2. Defaults, ch_sel=2, 3 btn_up presses -> duty_o=3. After the next period boundary, led[2] is high exactly 3 of every 10 clk; all other led bits are 0.
3. 12 up presses -> duty_o=10 and led[2] constant 1. Then 11 dn presses -> duty_o=0 and led[2] constant 0. Up+dn asserted simultaneously -> duty_o unchanged.
4. CH_N=6 instance, ch_sel=7, btn_up -> no duty changes and duty_o=0. ch_sel=5 up -> duty_o=1.
5. Duty 3, press up 4 times completing at phase 5 -> current period shows 3 high clk; the next period shows 7 high clk with no extra pulse.
6. BREATHE_DIV=2, PRESCALE=1: btn_mode -> mode=1. All leds share level 0,1,…,10,9,…,0 with one step per 20 clk. btn_mode -> mode=2 and led=0 next clk. btn_mode -> mode=0 and the prior manual duties are restored.
